// File: rtl/spi_frame_tx.sv
// spi_frame_tx: serializes a header word plus four 14-bit channel samples per frame
// onto a cs-framed SPI link (sck idle low, data changes on falling edges).
module spi_frame_tx #(
  parameter int unsigned DIV    = 2,
  parameter int unsigned CS_GAP = 4,
  parameter logic [13:0] HEADER = 14'h0FFF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [13:0] ch1,
  input  logic [13:0] ch2,
  input  logic [13:0] ch3,
  input  logic [13:0] ch4,
  output logic        sck,
  output logic        mosi,
  output logic        cs,
  output logic        busy,
  output logic        frame_done,
  output logic        collision
);

  localparam int unsigned      DIV_W    = $clog2(DIV + 1);
  localparam int unsigned      GAP_W    = $clog2(CS_GAP + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
  localparam logic [3:0]       BIT_LAST = 4'd13;
  localparam logic [2:0]       IDX_LAST = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic hits_header(input logic [13:0] v);
    return (v == HEADER);
  endfunction

  // A sample that would alias the header is nudged by one LSB so the receiver
  // can never mis-frame on payload data.
  function automatic logic [13:0] clamp_sample(input logic [13:0] v);
    logic [13:0] r;
    if (v == HEADER) begin
      r = HEADER ^ 14'h0001;
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t             state_r, state_s;
  logic [2:0]         idx_r, idx_s;
  logic [3:0]         bit_r, bit_s;
  logic [DIV_W-1:0]   div_r, div_s;
  logic [GAP_W-1:0]   gap_r, gap_s;
  logic               sck_r, sck_s;
  logic               mosi_r, mosi_s;
  logic               cs_r, cs_s;
  logic               s_ready_r, s_ready_s;
  logic               busy_r, busy_s;
  logic               frame_done_r, frame_done_s;
  logic               collision_r, collision_s;
  logic [3:0][13:0]   hold_r;
  logic               load_s;
  logic               accept_s;
  logic               clamp_any_s;
  logic [13:0]        cur_word_s;
  logic [13:0]        next_word_s;

  assign accept_s    = s_valid && s_ready_r && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign clamp_any_s = hits_header(ch1) | hits_header(ch2) | hits_header(ch3) | hits_header(ch4);

  // Word being shifted now, and the word the next SHIFT entry loads.
  always_comb begin
    cur_word_s  = HEADER;
    next_word_s = HEADER;
    case (idx_r)
      3'd0: begin
        cur_word_s  = HEADER;
        next_word_s = hold_r[0];
      end
      3'd1: begin
        cur_word_s  = hold_r[0];
        next_word_s = hold_r[1];
      end
      3'd2: begin
        cur_word_s  = hold_r[1];
        next_word_s = hold_r[2];
      end
      3'd3: begin
        cur_word_s  = hold_r[2];
        next_word_s = hold_r[3];
      end
      3'd4: begin
        cur_word_s  = hold_r[3];
        next_word_s = HEADER;
      end
      default: begin
        cur_word_s  = HEADER;
        next_word_s = HEADER;
      end
    endcase
  end

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    bit_s        = bit_r;
    div_s        = div_r;
    gap_s        = gap_r;
    sck_s        = sck_r;
    mosi_s       = mosi_r;
    cs_s         = cs_r;
    s_ready_s    = s_ready_r;
    busy_s       = busy_r;
    frame_done_s = 1'b0;
    collision_s  = 1'b0;
    load_s       = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          state_s     = ST_SHIFT;
          idx_s       = 3'd0;
          bit_s       = 4'd0;
          div_s       = '0;
          gap_s       = '0;
          sck_s       = 1'b0;
          mosi_s      = HEADER[13];
          cs_s        = 1'b0;
          s_ready_s   = 1'b0;
          busy_s      = 1'b1;
          collision_s = clamp_any_s;
          load_s      = 1'b1;
        end else begin
          state_s   = ST_IDLE;
          sck_s     = 1'b0;
          mosi_s    = 1'b0;
          cs_s      = 1'b1;
          s_ready_s = 1'b1;
          busy_s    = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (div_r == DIV_LAST) begin
          div_s = '0;
          if (!sck_r) begin
            sck_s = 1'b1;
          end else if (bit_r == BIT_LAST) begin
            // Last falling edge closes the word together with cs.
            sck_s   = 1'b0;
            cs_s    = 1'b1;
            mosi_s  = 1'b0;
            gap_s   = '0;
            state_s = ST_GAP;
          end else begin
            sck_s  = 1'b0;
            bit_s  = bit_r + 4'd1;
            mosi_s = cur_word_s[4'd12 - bit_r];
          end
        end else begin
          div_s = div_r + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_r == GAP_LAST) begin
          gap_s = '0;
          if (idx_r < IDX_LAST) begin
            idx_s   = idx_r + 3'd1;
            bit_s   = 4'd0;
            div_s   = '0;
            sck_s   = 1'b0;
            cs_s    = 1'b0;
            mosi_s  = next_word_s[13];
            state_s = ST_SHIFT;
          end else begin
            state_s      = ST_DONE;
            frame_done_s = 1'b1;
            busy_s       = 1'b0;
            s_ready_s    = 1'b1;
          end
        end else begin
          gap_s = gap_r + 1'b1;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        sck_s     = 1'b0;
        mosi_s    = 1'b0;
        cs_s      = 1'b1;
        s_ready_s = 1'b0;
        busy_s    = 1'b0;
      end
    endcase
  end

  // Sequencer state, counters and registered serial/handshake outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= ST_IDLE;
      idx_r        <= 3'd0;
      bit_r        <= 4'd0;
      div_r        <= '0;
      gap_r        <= '0;
      sck_r        <= 1'b0;
      mosi_r       <= 1'b0;
      cs_r         <= 1'b1;
      s_ready_r    <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      collision_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      bit_r        <= bit_s;
      div_r        <= div_s;
      gap_r        <= gap_s;
      sck_r        <= sck_s;
      mosi_r       <= mosi_s;
      cs_r         <= cs_s;
      s_ready_r    <= s_ready_s;
      busy_r       <= busy_s;
      frame_done_r <= frame_done_s;
      collision_r  <= collision_s;
    end
  end

  // Holding registers capture the clamped sample set on acceptance.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_r <= '0;
    end else if (load_s) begin
      hold_r <= {clamp_sample(ch4), clamp_sample(ch3), clamp_sample(ch2), clamp_sample(ch1)};
    end
  end

  assign sck        = sck_r;
  assign mosi       = mosi_r;
  assign cs         = cs_r;
  assign s_ready    = s_ready_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign collision  = collision_r;

endmodule

// File: tb/tb_spi_frame_tx.sv
// Directed bench for spi_frame_tx: a receiver model rebuilds words on sck rising
// edges and cs rising edges; default and DIV=1/CS_GAP=1 instances are exercised.
module tb_spi_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        s_valid, f_valid;
  logic [13:0] ch1, ch2, ch3, ch4;
  logic        s_ready, sck, mosi, cs, busy, frame_done, collision;
  logic        f_ready, f_sck, f_mosi, f_cs, f_busy, f_done, f_coll;

  spi_frame_tx dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready),
    .ch1(ch1), .ch2(ch2), .ch3(ch3), .ch4(ch4),
    .sck(sck), .mosi(mosi), .cs(cs), .busy(busy),
    .frame_done(frame_done), .collision(collision)
  );

  spi_frame_tx #(.DIV(1), .CS_GAP(1)) dut_fast (
    .clk(clk), .rstn(rstn), .s_valid(f_valid), .s_ready(f_ready),
    .ch1(ch1), .ch2(ch2), .ch3(ch3), .ch4(ch4),
    .sck(f_sck), .mosi(f_mosi), .cs(f_cs), .busy(f_busy),
    .frame_done(f_done), .collision(f_coll)
  );

  int vectors = 0;
  int errors  = 0;

  // Receiver model and cycle monitors for the default instance.
  logic [13:0] rx_sh;
  int          rx_bits;
  logic [13:0] rx_q[$];
  int          bits_q[$];
  int          low_q[$];
  int          cs_low, bad_idle, done_cnt, coll_cnt, sr_bad;
  logic        mon_sr;

  // Same for the fast instance.
  logic [13:0] f_sh;
  logic [13:0] f_q[$];
  int          f_low_q[$];
  int          f_gap_q[$];
  int          f_low, f_gap;

  always @(posedge sck) begin
    rx_sh = {rx_sh[12:0], mosi};
    rx_bits++;
  end

  always @(posedge cs) begin
    if (rstn) begin
      rx_q.push_back(rx_sh);
      bits_q.push_back(rx_bits);
    end
    rx_bits = 0;
  end

  always @(posedge f_sck) f_sh = {f_sh[12:0], f_mosi};

  always @(posedge f_cs) if (rstn) f_q.push_back(f_sh);

  always @(negedge clk) begin
    if (rstn) begin
      if (cs === 1'b0) begin
        cs_low++;
      end else if (cs_low != 0) begin
        low_q.push_back(cs_low);
        cs_low = 0;
      end
      if (cs === 1'b1 && (sck !== 1'b0 || mosi !== 1'b0)) bad_idle++;
      if (frame_done === 1'b1) done_cnt++;
      if (collision === 1'b1) coll_cnt++;
      if (mon_sr && s_ready === 1'b1 && frame_done !== 1'b1) sr_bad++;
      if (f_cs === 1'b0) begin
        f_low++;
        if (f_gap != 0) begin
          f_gap_q.push_back(f_gap);
          f_gap = 0;
        end
      end else begin
        if (f_low != 0) begin
          f_low_q.push_back(f_low);
          f_low = 0;
        end
        if (f_busy === 1'b1) begin
          f_gap++;
        end else if (f_gap != 0) begin
          f_gap_q.push_back(f_gap);
          f_gap = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    rx_q.delete(); bits_q.delete(); low_q.delete();
    f_q.delete(); f_low_q.delete(); f_gap_q.delete();
    rx_bits = 0; cs_low = 0; bad_idle = 0; done_cnt = 0; coll_cnt = 0; sr_bad = 0;
    f_low = 0; f_gap = 0; mon_sr = 1'b0;
  endtask

  function automatic logic [31:0] rx_word(input int k);
    if (k < rx_q.size()) return {18'd0, rx_q[k]};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] q_at(input int q[$], input int k);
    if (k < q.size()) return q[k];
    return 32'hFFFF_FFFF;
  endfunction

  // Drives a sample set, waits (bounded) for acceptance, returns cycles to frame_done.
  task automatic run_frame(input logic [13:0] a, b, c, d, output int len);
    int n;
    @(negedge clk);
    ch1 = a; ch2 = b; ch3 = c; ch4 = d;
    s_valid = 1'b1;
    n = 0;
    while (s_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 s_valid = 1'b0;
    len = 0;
    do begin
      @(negedge clk);
      len++;
    end while (frame_done !== 1'b1 && len < 2000);
  endtask

  task automatic check_frame(input string tag, input int base,
                             input logic [13:0] e1, e2, e3, e4);
    logic [13:0] exp_w [5];
    int hdrs;
    exp_w[0] = 14'h0FFF; exp_w[1] = e1; exp_w[2] = e2; exp_w[3] = e3; exp_w[4] = e4;
    hdrs = 0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("%s_word%0d", tag, k), rx_word(base + k), {18'd0, exp_w[k]});
      chk($sformatf("%s_bits%0d", tag, k), q_at(bits_q, base + k), 32'd14);
      chk($sformatf("%s_cslow%0d", tag, k), q_at(low_q, base + k), 32'd56);
      if (rx_word(base + k) == 32'h0000_0FFF) hdrs++;
    end
    chk($sformatf("%s_headers", tag), hdrs, 32'd1);
  endtask

  typedef struct packed {
    logic [13:0] c1, c2, c3, c4;
    logic [13:0] e1, e2, e3, e4;
    logic [7:0]  coll;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int len, n;
    vecs[0] = '{14'h1ABC, 14'h0800, 14'h3FFF, 14'h0000, 14'h1ABC, 14'h0800, 14'h3FFF, 14'h0000, 8'd0};
    vecs[1] = '{14'h0100, 14'h0FFF, 14'h0100, 14'h0100, 14'h0100, 14'h0FFE, 14'h0100, 14'h0100, 8'd1};
    vecs[2] = '{14'h0FFF, 14'h0FFF, 14'h0FFF, 14'h0FFF, 14'h0FFE, 14'h0FFE, 14'h0FFE, 14'h0FFE, 8'd1};
    vecs[3] = '{14'h2AAA, 14'h1555, 14'h0FFE, 14'h3000, 14'h2AAA, 14'h1555, 14'h0FFE, 14'h3000, 8'd0};

    rstn = 1'b0; s_valid = 1'b0; f_valid = 1'b0;
    ch1 = 14'h0; ch2 = 14'h0; ch3 = 14'h0; ch4 = 14'h0;
    clear_mon();
    repeat (3) @(negedge clk);
    chk("reset_outs", {s_ready, sck, mosi, cs, busy, frame_done, collision}, 7'b0001000);
    rstn = 1'b1;
    #1 chk("ready_before_edge", s_ready, 1'b0);
    @(negedge clk);
    chk("ready_after_release", s_ready, 1'b1);

    // Table-driven single frames.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 clear_mon();
      run_frame(vecs[i].c1, vecs[i].c2, vecs[i].c3, vecs[i].c4, len);
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_len", i), len, 32'd301);
      chk($sformatf("v%0d_nwords", i), rx_q.size(), 32'd5);
      check_frame($sformatf("v%0d", i), 0, vecs[i].e1, vecs[i].e2, vecs[i].e3, vecs[i].e4);
      chk($sformatf("v%0d_collision", i), coll_cnt, {24'd0, vecs[i].coll});
      chk($sformatf("v%0d_done", i), done_cnt, 32'd1);
      chk($sformatf("v%0d_idle_lines", i), bad_idle, 32'd0);
    end

    // Back-to-back frames with s_valid held high; inputs change mid-frame.
    @(posedge clk);
    #1 clear_mon();
    @(negedge clk);
    ch1 = 14'h0111; ch2 = 14'h0222; ch3 = 14'h0333; ch4 = 14'h0444;
    s_valid = 1'b1;
    n = 0;
    while (s_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 mon_sr = 1'b1;
    ch1 = 14'h1111; ch2 = 14'h1222; ch3 = 14'h1333; ch4 = 14'h1444;
    for (int f = 0; f < 3; f++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (s_ready !== 1'b1 && n < 2000);
      chk($sformatf("b2b_spacing%0d", f), n, 32'd301);
      if (f == 2) begin
        s_valid = 1'b0;
        mon_sr  = 1'b0;
      end else begin
        @(posedge clk);
        #1 ch1 = 14'h2000 + 14'(f); ch2 = 14'h2100; ch3 = 14'h2200; ch4 = 14'h2300;
      end
    end
    repeat (3) @(negedge clk);
    chk("b2b_nwords", rx_q.size(), 32'd15);
    check_frame("b2b_f0", 0, 14'h0111, 14'h0222, 14'h0333, 14'h0444);
    check_frame("b2b_f1", 5, 14'h1111, 14'h1222, 14'h1333, 14'h1444);
    check_frame("b2b_f2", 10, 14'h2000, 14'h2100, 14'h2200, 14'h2300);
    chk("b2b_done", done_cnt, 32'd3);
    chk("b2b_ready_only_done", sr_bad, 32'd0);

    // Reset during word 3, bit 7 (ch3 = 3FFF so mosi is high there).
    @(posedge clk);
    #1 clear_mon();
    @(negedge clk);
    ch1 = vecs[0].c1; ch2 = vecs[0].c2; ch3 = vecs[0].c3; ch4 = vecs[0].c4;
    s_valid = 1'b1;
    n = 0;
    while (s_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 s_valid = 1'b0;
    repeat (209) @(negedge clk);
    chk("rst_pre_cs_mosi", {cs, mosi}, 2'b01);
    #2 rstn = 1'b0;
    #1 chk("rst_async_outs", {sck, mosi, cs, s_ready, busy, frame_done}, 6'b001000);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1 clear_mon();
    repeat (400) @(negedge clk);
    chk("rst_no_done", done_cnt, 32'd0);
    chk("rst_no_words", rx_q.size(), 32'd0);
    chk("rst_ready", s_ready, 1'b1);
    run_frame(vecs[3].c1, vecs[3].c2, vecs[3].c3, vecs[3].c4, len);
    repeat (3) @(negedge clk);
    chk("rst_next_len", len, 32'd301);
    check_frame("rst_next", 0, vecs[3].e1, vecs[3].e2, vecs[3].e3, vecs[3].e4);

    // DIV=1, CS_GAP=1 instance.
    @(posedge clk);
    #1 clear_mon();
    @(negedge clk);
    ch1 = vecs[0].c1; ch2 = vecs[0].c2; ch3 = vecs[0].c3; ch4 = vecs[0].c4;
    f_valid = 1'b1;
    n = 0;
    while (f_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 f_valid = 1'b0;
    len = 0;
    do begin
      @(negedge clk);
      len++;
    end while (f_done !== 1'b1 && len < 2000);
    repeat (3) @(negedge clk);
    chk("fast_len", len, 32'd146);
    chk("fast_nwords", f_q.size(), 32'd5);
    chk("fast_ngaps", f_gap_q.size(), 32'd5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("fast_cslow%0d", k), q_at(f_low_q, k), 32'd28);
      chk($sformatf("fast_gap%0d", k), q_at(f_gap_q, k), 32'd1);
    end
    if (f_q.size() == 5) begin
      chk("fast_word0", f_q[0], 14'h0FFF);
      chk("fast_word1", f_q[1], vecs[0].e1);
      chk("fast_word3", f_q[3], vecs[0].e3);
    end else begin
      chk("fast_words_present", f_q.size(), 32'd5);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
